// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU bus arbiter: size encodings and FSM states.
package cpu_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Master-index width; a single-port build still needs one bit to index with.
  function automatic int id_width(input int num_m);
    return (num_m > 1) ? $clog2(num_m) : 1;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of issuing-master IDs for accepted, not-yet-answered requests.
module arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Arbitrates NUM_M sram-like master ports onto one slave port, routing responses in order.
// Define BUS_ARB_RR_EN for round-robin arbitration; default is fixed priority (highest index wins).
//
//  state   | meaning
//  ST_IDLE | no held grant; winner of this cycle drives the slave combinationally
//  ST_BUSY | grant frozen on one master until its request is accepted or withdrawn
module cpu_bus_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_M-1:0]    m_req,
  input  logic [NUM_M-1:0]    m_wr,
  input  logic [2*NUM_M-1:0]  m_size,
  input  logic [AW*NUM_M-1:0] m_addr,
  input  logic [DW*NUM_M-1:0] m_wdata,
  output logic [NUM_M-1:0]    m_addr_ok,
  output logic [NUM_M-1:0]    m_data_ok,
  output logic [DW-1:0]       m_rdata,
  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [AW-1:0]     s_addr,
  output logic [DW-1:0]     s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DW-1:0]     s_rdata,
  output logic              err
);

  localparam int IDW = id_width(NUM_M);

  arb_state_e     state;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cur;
  logic [IDW-1:0] head;
  logic           any_req;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           pop;

`ifdef BUS_ARB_RR_EN
  logic [IDW-1:0] last_grant;

  // Search starts one past the last grant and wraps around the ports.
  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_M; k++) begin
      if (!found && m_req[(int'(last_grant) + k) % NUM_M]) begin
        winner = IDW'((int'(last_grant) + k) % NUM_M);
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (m_req[i]) winner = IDW'(i);
    end
  end
`endif

  assign any_req = |m_req;
  assign cur     = (state == ST_BUSY) ? grant : winner;

  // A full ID FIFO stalls the slave request even if a response pops this cycle.
  assign s_req   = ~fifo_full & ((state == ST_BUSY) ? m_req[grant] : any_req);
  assign s_wr    = m_wr[cur];
  assign s_size  = m_size[int'(cur)*2 +: 2];
  assign s_addr  = m_addr[int'(cur)*AW +: AW];
  assign s_wdata = m_wdata[int'(cur)*DW +: DW];

  assign accept    = s_req & s_addr_ok;
  assign pop       = s_data_ok & ~fifo_empty;
  assign m_addr_ok = accept ? (NUM_M'(1) << cur) : '0;
  assign m_data_ok = pop ? (NUM_M'(1) << head) : '0;
  assign m_rdata   = s_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= '0;
      err   <= 1'b0;
`ifdef BUS_ARB_RR_EN
      last_grant <= IDW'(NUM_M - 1);
`endif
    end else begin
      if (s_data_ok && fifo_empty) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (s_req) begin
            grant <= winner;
`ifdef BUS_ARB_RR_EN
            last_grant <= winner;
`endif
            if (!s_addr_ok) state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept || !m_req[grant]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  arb_id_fifo #(
    .DEPTH(DEPTH),
    .W    (IDW)
  ) u_id_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (accept),
    .pop  (pop),
    .din  (cur),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head)
  );

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed vector table, corner sequences, random vs model.
module tb_cpu_bus_arbiter;
  import cpu_bus_pkg::*;

  localparam int N     = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]    m_req, m_wr, m_addr_ok, m_data_ok;
  logic [2*N-1:0]  m_size;
  logic [AW*N-1:0] m_addr;
  logic [DW*N-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]   s_addr;
  logic [1:0]      s_size;
  logic            s_req, s_wr, s_addr_ok, s_data_ok, err;

  int errors = 0;
  int checks = 0;

  cpu_bus_arbiter #(.NUM_M(N), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic aok, input logic dok,
                       input logic [31:0] rdata);
    m_req = req; s_addr_ok = aok; s_data_ok = dok; s_rdata = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // ---------------- behavioural reference model ----------------
  int mq[$];     // IDs awaiting a response, oldest first
  int mh;        // master holding the grant, -1 when none
  bit merr;
  int mlast;

  task automatic model_reset();
    mq.delete(); mh = -1; merr = 1'b0; mlast = N - 1;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    int w, i;
    w = -1;
`ifdef BUS_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      i = (mlast + k) % N;
      if (w < 0 && r[i]) w = i;
    end
`else
    for (i = 0; i < N; i++) if (r[i]) w = i;
`endif
    return w;
  endfunction

  task automatic model_eval(output bit sreq, output int cur,
                            output logic [N-1:0] eaok, output logic [N-1:0] edok);
    sreq = 1'b0; cur = -1;
    if (mq.size() < DEPTH) begin
      if (mh >= 0) begin
        if (m_req[mh]) begin sreq = 1'b1; cur = mh; end
      end else if (m_req != 0) begin
        sreq = 1'b1; cur = pick(m_req);
      end
    end
    eaok = (sreq && s_addr_ok) ? N'(1 << cur) : '0;
    edok = (s_data_ok && mq.size() > 0) ? N'(1 << mq[0]) : '0;
  endtask

  task automatic model_update(input bit sreq, input int cur);
    bit idle_grant;
    idle_grant = (mh < 0) && sreq;
    if (s_data_ok) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else merr = 1'b1;
    end
    if (idle_grant) mlast = cur;
    if (sreq && s_addr_ok) begin
      mq.push_back(cur);
      mh = -1;
    end else if (idle_grant) mh = cur;
    else if (mh >= 0 && !m_req[mh]) mh = -1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic [1:0]  e_aok;
    logic [1:0]  e_dok;
    logic        e_sreq;
    int          e_src;
    logic        e_err;
  } vec_t;

  vec_t tv[18];
  logic [31:0] port_addr[N];

  bit          r_sreq;
  int          r_cur;
  logic [N-1:0] r_eaok, r_edok;
  logic [66:0] exp_bus;

  initial begin
    port_addr[0] = 32'hBFC0_0000;
    port_addr[1] = 32'h8000_1000;

    tv[0]  = '{2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 0, 1'b0};
    tv[1]  = '{2'b00, 1'b0, 1'b1, 32'h2402_0001, 2'b00, 2'b01, 1'b0, 0, 1'b0};
    tv[2]  = '{2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 0, 1'b0};
    tv[3]  = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 0, 1'b0};
    tv[4]  = '{2'b11, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 0, 1'b0};
    tv[5]  = '{2'b11, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 0, 1'b0};
    tv[6]  = '{2'b10, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 1'b1, 1, 1'b0};
    tv[7]  = '{2'b01, 1'b1, 1'b0, 32'h0,         2'b01, 2'b00, 1'b1, 0, 1'b0};
    tv[8]  = '{2'b00, 1'b0, 1'b1, 32'h1111_1111, 2'b00, 2'b01, 1'b0, 0, 1'b0};
    tv[9]  = '{2'b01, 1'b1, 1'b1, 32'h2222_2222, 2'b01, 2'b10, 1'b1, 0, 1'b0};
    tv[10] = '{2'b00, 1'b0, 1'b1, 32'h3333_3333, 2'b00, 2'b01, 1'b0, 0, 1'b0};
    tv[11] = '{2'b00, 1'b0, 1'b1, 32'h4444_4444, 2'b00, 2'b01, 1'b0, 0, 1'b0};
    tv[12] = '{2'b00, 1'b0, 1'b1, 32'h5555_5555, 2'b00, 2'b00, 1'b0, 0, 1'b0};
    tv[13] = '{2'b00, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 0, 1'b1};
    tv[14] = '{2'b01, 1'b0, 1'b0, 32'h0,         2'b00, 2'b00, 1'b1, 0, 1'b1};
    tv[15] = '{2'b10, 1'b1, 1'b0, 32'h0,         2'b00, 2'b00, 1'b0, 0, 1'b1};
    tv[16] = '{2'b10, 1'b1, 1'b0, 32'h0,         2'b10, 2'b00, 1'b1, 1, 1'b1};
    tv[17] = '{2'b00, 1'b0, 1'b1, 32'h6666_6666, 2'b00, 2'b10, 1'b0, 0, 1'b1};

    m_wr    = 2'b10;
    m_size  = {SZ_WORD, SZ_WORD};
    m_addr  = {port_addr[1], port_addr[0]};
    m_wdata = {32'hCAFE_0001, 32'hCAFE_0000};
    #1;
    do_reset();

    chk("reset_s_req", s_req, 1'b0);
    chk("reset_addr_ok", m_addr_ok, 2'b00);
    chk("reset_data_ok", m_data_ok, 2'b00);
    chk("reset_err", err, 1'b0);

    for (int i = 0; i < 18; i++) begin
      drive(tv[i].req, tv[i].aok, tv[i].dok, tv[i].rdata);
      #4;
      chk($sformatf("tv%0d_s_req", i), s_req, tv[i].e_sreq);
      chk($sformatf("tv%0d_addr_ok", i), m_addr_ok, tv[i].e_aok);
      chk($sformatf("tv%0d_data_ok", i), m_data_ok, tv[i].e_dok);
      chk($sformatf("tv%0d_err", i), err, tv[i].e_err);
      if (tv[i].e_sreq) chk($sformatf("tv%0d_s_addr", i), s_addr, port_addr[tv[i].e_src]);
      if (tv[i].e_dok != 0) chk($sformatf("tv%0d_rdata", i), m_rdata, tv[i].rdata);
      next_cycle();
    end

    // Both ports requesting every cycle with an always-ready slave.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0, 32'h0);
      #4;
`ifdef BUS_ARB_RR_EN
      chk($sformatf("contend%0d", i), m_addr_ok, (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      chk($sformatf("contend%0d", i), m_addr_ok, 2'b10);
`endif
      next_cycle();
    end

    // Full FIFO: four accepts, then stall; a pop alone does not unblock the same cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      #4;
      chk($sformatf("full%0d_s_req", i), s_req, (i < DEPTH) ? 1'b1 : 1'b0);
      chk($sformatf("full%0d_addr_ok", i), m_addr_ok, (i < DEPTH) ? 2'b01 : 2'b00);
      next_cycle();
    end
    drive(2'b01, 1'b1, 1'b1, 32'hABCD_0000);
    #4;
    chk("full_pop_s_req", s_req, 1'b0);
    chk("full_pop_data_ok", m_data_ok, 2'b01);
    next_cycle();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    #4;
    chk("full_after_pop_addr_ok", m_addr_ok, 2'b01);
    next_cycle();

    // Reset with two requests outstanding; their late responses are orphans.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 1'b1, 1'b0, 32'h0);
      next_cycle();
    end
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'h1234_5678);
    #4;
    chk("rstmid_data_ok", m_data_ok, 2'b00);
    next_cycle();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #4;
      chk($sformatf("rstmid_err%0d", i), err, 1'b1);
      next_cycle();
    end

    // Randomised traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      m_req     = N'($urandom_range(0, 3));
      m_wr      = N'($urandom);
      m_size    = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      m_addr    = {$urandom, $urandom};
      m_wdata   = {$urandom, $urandom};
      s_addr_ok = ($urandom_range(0, 1) == 1);
      s_data_ok = (mq.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 2);
      s_rdata   = $urandom;
      model_eval(r_sreq, r_cur, r_eaok, r_edok);
      #4;
      chk("rnd_s_req", s_req, r_sreq);
      chk("rnd_addr_ok", m_addr_ok, r_eaok);
      chk("rnd_data_ok", m_data_ok, r_edok);
      chk("rnd_err", err, merr);
      if (r_sreq) begin
        exp_bus = {m_wr[r_cur], m_size[r_cur*2 +: 2], m_addr[r_cur*AW +: AW],
                   m_wdata[r_cur*DW +: DW]};
        chk("rnd_s_bus_hi", {s_wr, s_size, s_addr}, 64'(exp_bus[66:32]));
        chk("rnd_s_wdata", s_wdata, exp_bus[31:0]);
      end
      if (r_edok != 0) chk("rnd_rdata", m_rdata, s_rdata);
      @(posedge clk);
      model_update(r_sreq, r_cur);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
